// File: rtl/reg_op_sequencer.sv
// ============================================================================
// reg_op_sequencer
// ----------------------------------------------------------------------------
// Initiator side of the register file read/write port. Accepts one
// register-to-register micro-op at a time (ADD, SUB, MOV, LDI) over a
// valid/ready handshake, reads its operands from the register file, computes
// the result and writes it back to the destination register.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   op_valid / op_ready   micro-op handshake (op_ready only in IDLE)
//   op_code               00 ADD, 01 SUB, 10 MOV, 11 LDI
//   op_dst/op_src0/op_src1/op_imm   micro-op fields
//   rf_rd_en, rf_rd0_addr, rf_rd1_addr   register file read request
//   rf_rd0_data, rf_rd1_data             read data, valid one cycle later
//   rf_wr_en, rf_wr_addr, rf_wr_data     register file write
//   done                  one-cycle pulse coincident with the write
//   result                last written value, held
//   ovf                   signed overflow of the last ADD/SUB, held
// ============================================================================
module reg_op_sequencer #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] op_dst,
    input  logic [ADDR_W-1:0] op_src0,
    input  logic [ADDR_W-1:0] op_src1,
    input  logic [DATA_W-1:0] op_imm,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd0_addr,
    output logic [ADDR_W-1:0] rf_rd1_addr,
    input  logic [DATA_W-1:0] rf_rd0_data,
    input  logic [DATA_W-1:0] rf_rd1_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    localparam int MSB = DATA_W - 1;

    state_t              state_q,    state_d;
    logic [1:0]          code_q,     code_d;
    logic [ADDR_W-1:0]   dst_q,      dst_d;
    logic [ADDR_W-1:0]   rd0_addr_q, rd0_addr_d;
    logic [ADDR_W-1:0]   rd1_addr_q, rd1_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q,  wr_data_d;
    logic [DATA_W-1:0]   result_q,   result_d;
    logic                ovf_q,      ovf_d;

    // Operand arithmetic, wrap-around at DATA_W bits.
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    assign sum  = rf_rd0_data + rf_rd1_data;
    assign diff = rf_rd0_data - rf_rd1_data;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        dst_d      = dst_q;
        rd0_addr_d = rd0_addr_q;
        rd1_addr_d = rd1_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        result_d   = result_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    code_d = op_code;
                    dst_d  = op_dst;
                    if (op_code == OP_LDI) begin
                        // LDI skips the read: write port is set up directly.
                        wr_addr_d = op_dst;
                        wr_data_d = op_imm;
                        ovf_d     = 1'b0;
                        state_d   = S_WRITE;
                    end else begin
                        // Read addresses are loaded at accept so they are
                        // already on the port during READ.
                        rd0_addr_d = op_src0;
                        rd1_addr_d = (op_code == OP_MOV) ? op_src0 : op_src1;
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                wr_addr_d = dst_q;
                case (code_q)
                    OP_ADD: begin
                        wr_data_d = sum;
                        ovf_d = (rf_rd0_data[MSB] == rf_rd1_data[MSB]) &&
                                (sum[MSB] != rf_rd0_data[MSB]);
                    end
                    OP_SUB: begin
                        // Overflow only when operand signs differ (A - B).
                        wr_data_d = diff;
                        ovf_d = (rf_rd0_data[MSB] != rf_rd1_data[MSB]) &&
                                (diff[MSB] != rf_rd0_data[MSB]);
                    end
                    default: begin
                        wr_data_d = rf_rd0_data;
                        ovf_d     = 1'b0;
                    end
                endcase
                state_d = S_WRITE;
            end
            S_WRITE: begin
                result_d = wr_data_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            code_q     <= '0;
            dst_q      <= '0;
            rd0_addr_q <= '0;
            rd1_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            dst_q      <= dst_d;
            rd0_addr_q <= rd0_addr_d;
            rd1_addr_q <= rd1_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
        end
    end

    assign op_ready    = (state_q == S_IDLE);
    assign rf_rd_en    = (state_q == S_READ);
    assign rf_wr_en    = (state_q == S_WRITE);
    assign done        = (state_q == S_WRITE);
    assign rf_rd0_addr = rd0_addr_q;
    assign rf_rd1_addr = rd1_addr_q;
    assign rf_wr_addr  = wr_addr_q;
    assign rf_wr_data  = wr_data_q;
    assign result      = result_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// ============================================================================
// tb_reg_op_sequencer
// ----------------------------------------------------------------------------
// Directed testbench for reg_op_sequencer. A small register file model sits on
// the DUT's read/write port (registered read, one-cycle latency). Inputs are
// driven and outputs sampled on the falling clock edge.
// ============================================================================
module tb_reg_op_sequencer;

    localparam int DATA_W = 9;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_code;
    logic [ADDR_W-1:0] op_dst;
    logic [ADDR_W-1:0] op_src0;
    logic [ADDR_W-1:0] op_src1;
    logic [DATA_W-1:0] op_imm;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_rd0_addr;
    logic [ADDR_W-1:0] rf_rd1_addr;
    logic [DATA_W-1:0] rf_rd0_data;
    logic [DATA_W-1:0] rf_rd1_data;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              ovf;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int wr_cnt = 0;

    logic [DATA_W-1:0] rf_mem [4];

    always #5 clk = ~clk;

    reg_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_dst      (op_dst),
        .op_src0     (op_src0),
        .op_src1     (op_src1),
        .op_imm      (op_imm),
        .rf_rd_en    (rf_rd_en),
        .rf_rd0_addr (rf_rd0_addr),
        .rf_rd1_addr (rf_rd1_addr),
        .rf_rd0_data (rf_rd0_data),
        .rf_rd1_data (rf_rd1_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .done        (done),
        .result      (result),
        .ovf         (ovf)
    );

    // Register file model: registered read, write on the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
            rf_rd0_data <= '0;
            rf_rd1_data <= '0;
        end else begin
            if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
            if (rf_rd_en) begin
                rf_rd0_data <= rf_mem[rf_rd0_addr];
                rf_rd1_data <= rf_mem[rf_rd1_addr];
            end
        end
    end

    // Handshake and write event counters.
    always @(posedge clk) begin
        if (op_valid && op_ready) acc_cnt <= acc_cnt + 1;
        if (rf_wr_en) wr_cnt <= wr_cnt + 1;
    end

    // Issue one op and wait (bounded) until its write has completed.
    task automatic do_op(input logic [1:0] code, input logic [1:0] dst,
                         input logic [1:0] s0, input logic [1:0] s1,
                         input logic [8:0] imm);
        int n;
        n = 0;
        while (!op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        op_valid = 1'b1;
        op_code  = code;
        op_dst   = dst;
        op_src0  = s0;
        op_src1  = s1;
        op_imm   = imm;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (!done && n < 6) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL do_op_done: no done pulse, got done=%0b required 1", done);
        end
        @(negedge clk);
        $display("op code=%0d dst=%0d src0=%0d src1=%0d imm=%0d -> result=%0d ovf=%0b",
                 code, dst, s0, s1, imm, $signed(result), ovf);
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = '0;
        op_dst   = '0;
        op_src0  = '0;
        op_src1  = '0;
        op_imm   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", op_ready); end
        checks++;
        if ({rf_rd_en, rf_wr_en, done, ovf} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got rd=%0b wr=%0b done=%0b ovf=%0b required all 0",
                               rf_rd_en, rf_wr_en, done, ovf);
        end
        checks++;
        if ({rf_rd0_addr, rf_rd1_addr, rf_wr_addr} !== 6'd0 || rf_wr_data !== 9'd0 || result !== 9'd0) begin
            errors++; $display("FAIL reset_values: got a0=%0d a1=%0d wa=%0d wd=%0d res=%0d required all 0",
                               rf_rd0_addr, rf_rd1_addr, rf_wr_addr, rf_wr_data, result);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset done");
    endtask

    task automatic test_ldi;
        op_valid = 1'b1;
        op_code  = 2'b11;
        op_dst   = 2'd2;
        op_src0  = 2'd0;
        op_src1  = 2'd0;
        op_imm   = 9'b101010101;
        @(negedge clk);
        op_valid = 1'b0;
        checks++;
        if ({rf_wr_en, done, rf_rd_en, op_ready} !== 4'b1100) begin
            errors++; $display("FAIL ldi_strobes: got wr=%0b done=%0b rd=%0b ready=%0b required 1 1 0 0",
                               rf_wr_en, done, rf_rd_en, op_ready);
        end
        checks++;
        if (rf_wr_addr !== 2'd2 || rf_wr_data !== 9'h155) begin
            errors++; $display("FAIL ldi_write: got addr=%0d data=%0d required addr=2 data=-171",
                               rf_wr_addr, $signed(rf_wr_data));
        end
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1 || done !== 1'b0 || result !== 9'h155 || rf_mem[2] !== 9'h155) begin
            errors++; $display("FAIL ldi_after: got ready=%0b done=%0b result=%0d r2=%0d required 1 0 -171 -171",
                               op_ready, done, $signed(result), $signed(rf_mem[2]));
        end
        $display("ldi r2=-171 checked");
    endtask

    task automatic test_add;
        do_op(2'b11, 2'd0, 2'd0, 2'd0, 9'd100);
        do_op(2'b11, 2'd1, 2'd0, 2'd0, 9'd50);
        op_valid = 1'b1;
        op_code  = 2'b00;
        op_dst   = 2'd3;
        op_src0  = 2'd0;
        op_src1  = 2'd1;
        @(negedge clk);
        op_valid = 1'b0;
        checks++;
        if (rf_rd_en !== 1'b1 || rf_rd0_addr !== 2'd0 || rf_rd1_addr !== 2'd1 || op_ready !== 1'b0) begin
            errors++; $display("FAIL add_read: got rd=%0b a0=%0d a1=%0d ready=%0b required 1 0 1 0",
                               rf_rd_en, rf_rd0_addr, rf_rd1_addr, op_ready);
        end
        @(negedge clk);
        checks++;
        if (rf_rd_en !== 1'b0 || rf_wr_en !== 1'b0) begin
            errors++; $display("FAIL add_exec: got rd=%0b wr=%0b required 0 0", rf_rd_en, rf_wr_en);
        end
        @(negedge clk);
        checks++;
        if (rf_wr_en !== 1'b1 || done !== 1'b1 || rf_wr_addr !== 2'd3 || rf_wr_data !== 9'd150) begin
            errors++; $display("FAIL add_write: got wr=%0b done=%0b addr=%0d data=%0d required 1 1 3 150",
                               rf_wr_en, done, rf_wr_addr, $signed(rf_wr_data));
        end
        @(negedge clk);
        checks++;
        if (result !== 9'd150 || ovf !== 1'b0 || rf_mem[3] !== 9'd150) begin
            errors++; $display("FAIL add_result: got result=%0d ovf=%0b r3=%0d required 150 0 150",
                               $signed(result), ovf, $signed(rf_mem[3]));
        end
        $display("add 100+50 checked");
    endtask

    task automatic test_ovf;
        // 200 + 100 = 300 -> wraps to -212 (0x12C)
        do_op(2'b11, 2'd0, 2'd0, 2'd0, 9'd200);
        do_op(2'b11, 2'd1, 2'd0, 2'd0, 9'd100);
        do_op(2'b00, 2'd3, 2'd0, 2'd1, 9'd0);
        checks++;
        if (result !== 9'h12C || ovf !== 1'b1) begin
            errors++; $display("FAIL add_ovf: got result=%0d ovf=%0b required -212 1", $signed(result), ovf);
        end
        // LDI clears a held overflow
        do_op(2'b11, 2'd0, 2'd0, 2'd0, 9'h138);
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ldi_clears_ovf: got ovf=%0b required 0", ovf);
        end
        // -200 - 100 = -300 -> wraps to 212
        do_op(2'b01, 2'd2, 2'd0, 2'd1, 9'd0);
        checks++;
        if (result !== 9'd212 || ovf !== 1'b1 || rf_mem[2] !== 9'd212) begin
            errors++; $display("FAIL sub_ovf: got result=%0d ovf=%0b r2=%0d required 212 1 212",
                               $signed(result), ovf, $signed(rf_mem[2]));
        end
        // MOV r1 <- r2 (src1 set to 3 to show it is ignored), clears ovf
        op_valid = 1'b1;
        op_code  = 2'b10;
        op_dst   = 2'd1;
        op_src0  = 2'd2;
        op_src1  = 2'd3;
        @(negedge clk);
        op_valid = 1'b0;
        checks++;
        if (rf_rd0_addr !== 2'd2 || rf_rd1_addr !== 2'd2) begin
            errors++; $display("FAIL mov_read_addr: got a0=%0d a1=%0d required 2 2", rf_rd0_addr, rf_rd1_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 9'd212 || ovf !== 1'b0 || rf_mem[1] !== 9'd212) begin
            errors++; $display("FAIL mov_result: got result=%0d ovf=%0b r1=%0d required 212 0 212",
                               $signed(result), ovf, $signed(rf_mem[1]));
        end
        // Non-overflowing SUB: 212 - 212 = 0
        do_op(2'b01, 2'd3, 2'd2, 2'd1, 9'd0);
        checks++;
        if (result !== 9'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL sub_zero: got result=%0d ovf=%0b required 0 0", $signed(result), ovf);
        end
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = wr_cnt;
        op_valid = 1'b1;
        op_code  = 2'b11;
        op_dst   = 2'd0;
        op_imm   = 9'd7;
        @(negedge clk);
        // Next op presented immediately, held until accepted.
        op_code  = 2'b10;
        op_dst   = 2'd1;
        op_src0  = 2'd0;
        op_src1  = 2'd2;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %0b required 1", op_ready);
        end
        @(negedge clk);
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rf_mem[1] !== 9'd7 || result !== 9'd7 || (wr_cnt - w0) != 2) begin
            errors++; $display("FAIL b2b_mov: got r1=%0d result=%0d writes=%0d required 7 7 2",
                               $signed(rf_mem[1]), $signed(result), wr_cnt - w0);
        end
        $display("back-to-back ldi/mov checked");
    endtask

    task automatic test_busy;
        int a0;
        int w0;
        a0 = acc_cnt;
        w0 = wr_cnt;
        op_valid = 1'b1;
        op_code  = 2'b10;
        op_dst   = 2'd3;
        op_src0  = 2'd0;
        op_src1  = 2'd0;
        repeat (12) @(negedge clk);
        op_valid = 1'b0;
        checks++;
        if ((acc_cnt - a0) != 3) begin
            errors++; $display("FAIL busy_accepts: got %0d required 3", acc_cnt - a0);
        end
        checks++;
        if ((wr_cnt - w0) != 3 || rf_mem[3] !== 9'd7) begin
            errors++; $display("FAIL busy_writes: got writes=%0d r3=%0d required 3 7",
                               wr_cnt - w0, $signed(rf_mem[3]));
        end
        $display("held op_valid: accepts=%0d writes=%0d", acc_cnt - a0, wr_cnt - w0);
    endtask

    task automatic test_reset_mid;
        int w0;
        op_valid = 1'b1;
        op_code  = 2'b00;
        op_dst   = 2'd2;
        op_src0  = 2'd0;
        op_src1  = 2'd1;
        @(negedge clk);          // READ
        op_valid = 1'b0;
        @(negedge clk);          // EXEC
        w0  = wr_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rf_wr_en !== 1'b0 || done !== 1'b0 || op_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_state: got wr=%0b done=%0b ready=%0b required 0 0 1",
                               rf_wr_en, done, op_ready);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ((wr_cnt - w0) != 0 || result !== 9'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL reset_mid_nowrite: got writes=%0d result=%0d ovf=%0b required 0 0 0",
                               wr_cnt - w0, $signed(result), ovf);
        end
        $display("reset during EXEC checked");
    endtask

    initial begin
        test_reset;
        test_ldi;
        test_add;
        test_ovf;
        test_back_to_back;
        test_busy;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1);
    end

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Initiator side of the register file read/write port. Accepts one register-to-register micro-op at a time over a valid/ready handshake and drives the register file's rd_en/rd0_addr/rd1_addr/wr_en/wr_addr/wr_data port.
- Captures the registered read data, computes an ADD/SUB/MOV result or takes an immediate, and writes it back.
- Sits between the instruction decode stage and the register file in the MIPS datapath.

Parameters:
DATA_W, 9, width of register data (signed two's complement)
ADDR_W, 2, width of register address (2^ADDR_W registers)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
op_valid  input  1  micro-op request valid
op_ready  output  1  sequencer can accept a micro-op
op_code  input  2  00 ADD, 01 SUB, 10 MOV, 11 LDI
op_dst  input  ADDR_W  destination register
op_src0  input  ADDR_W  source register A
op_src1  input  ADDR_W  source register B (ADD/SUB only)
op_imm  input  DATA_W  immediate (LDI only)
rf_rd_en  output  1  register file read enable
rf_rd0_addr  output  ADDR_W  read port 0 address
rf_rd1_addr  output  ADDR_W  read port 1 address
rf_rd0_data  input  DATA_W  read port 0 data, valid the cycle after rf_rd_en
rf_rd1_data  input  DATA_W  read port 1 data, valid the cycle after rf_rd_en
rf_wr_en  output  1  register file write enable
rf_wr_addr  output  ADDR_W  write address
rf_wr_data  output  DATA_W  write data
done  output  1  one-cycle pulse, coincident with the write cycle
result  output  DATA_W  last written value, held until the next write
ovf  output  1  signed overflow of the last ADD/SUB, held; cleared by MOV/LDI

Behaviour:
- Reset (rst high at an edge): state IDLE. op_ready=1. rf_rd_en, rf_wr_en, done, ovf = 0. All addresses, rf_wr_data and result = 0.
- Reset takes priority in every state. A reset mid-operation aborts the op; no write is issued in or after the reset cycle.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - op_ready=1; only IDLE asserts op_ready.
  - On op_valid&op_ready, latch op_code/dst/src0/src1/imm.
  - Next state is WRITE for LDI, READ otherwise.
- READ (1 cycle):
  - rf_rd_en=1, rf_rd0_addr=src0, rf_rd1_addr=src1.
  - For MOV, rf_rd1_addr=src0.
  - Next state EXEC.
- EXEC (1 cycle):
  - rf_rd_en=0.
  - Sample rf_rd0_data and rf_rd1_data; compute and register the result into the write-data register.
  - ADD: A+B. SUB: A-B. MOV: A.
  - Arithmetic is DATA_W-bit wrap-around.
  - ovf is registered as (sign(A)==sign(B') && sign(res)!=sign(A)), where B' = B for ADD and -B for SUB. SUB overflow is computed on the true A-B, i.e. A>=0, B<0 and res<0, or A<0, B>=0 and res>=0.
  - Next state WRITE.
- WRITE (1 cycle):
  - rf_wr_en=1, rf_wr_addr=dst, rf_wr_data=the computed value (op_imm for LDI).
  - done=1 and result updates at the end of this cycle.
  - Next state IDLE.
- Latency from the accept edge to the write edge: ADD/SUB/MOV 3 cycles; LDI 1 cycle. Throughput: one op per 4 cycles (2 for LDI).
- Outside their own state, rf_rd_en and rf_wr_en are 0. Addresses and wr_data hold their last values; these are don't-care when the enables are 0.
- rf_rd_en and rf_wr_en are never asserted in the same cycle, so there are no read/write collisions.
- A back-to-back op reading the register just written sees the new value: the write edge precedes the next READ edge.
- op_valid while op_ready=0 is ignored. The source must hold its request until accepted; no buffering.
- dst may equal src0/src1; the read completes before the write.

Test Plan:
- Reset: assert rst 1 cycle -> all outputs 0, op_ready=1. Assert rst while in EXEC -> no rf_wr_en pulse follows, back in IDLE.
- LDI dst=2, imm=9'b101010101 -> next cycle rf_wr_en=1, rf_wr_addr=2, rf_wr_data=-171, done=1; op_ready=1 the cycle after.
- With r0=100 and r1=50, ADD dst=3 src0=0 src1=1:
  - rf_rd_en=1 with addrs 0/1 one cycle after accept.
  - Write of 150 to r3 three cycles after accept; ovf=0.
- With r0=200 and r1=100, ADD -> wraps to -212, ovf=1. With r0=-200 and r1=100, SUB -> wraps to 212, ovf=1. A following MOV clears ovf.
- Back-to-back: LDI r0=7, then MOV dst=1 src0=0 presented immediately -> r1 written with 7.
- op_valid held high through a full op -> exactly one accept per IDLE visit. Ops presented while busy are not accepted, and no extra writes occur.
